// File: rtl/seq_detect_ctrl.sv
// Word-to-bit serializer feeding a programmable pattern matcher with per-frame match counting.
// Optional build macro SEQ_CTRL_LSB_FIRST_EN serializes in_data[0] first (default: MSB first).
module seq_detect_ctrl #(
    parameter int unsigned WORD_W  = 8,
    parameter int unsigned PAT_MAX = 8,
    parameter int unsigned CNT_W   = 8
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               cfg_we,
    input  logic [PAT_MAX-1:0] cfg_pattern,
    input  logic [3:0]         cfg_len,
    input  logic               cfg_overlap,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [WORD_W-1:0]  in_data,
    input  logic               in_last,
    output logic               seq_seen,
    output logic [CNT_W-1:0]   match_count,
    output logic               busy,
    output logic               done
);

    localparam int unsigned IDX_W = (WORD_W > 1) ? $clog2(WORD_W) : 1;
    localparam int unsigned HC_W  = $clog2(PAT_MAX + 1);
    localparam int unsigned LEN_W = HC_W;

    localparam logic [PAT_MAX-1:0] DEF_PAT = PAT_MAX'(4'b1011);
    localparam logic [LEN_W-1:0]   DEF_LEN = LEN_W'((PAT_MAX < 4) ? PAT_MAX : 4);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_SHIFT = 2'd1,
        S_DONE  = 2'd2
    } state_t;

    state_t             state;
    logic [WORD_W-1:0]  shift_reg;
    logic [IDX_W-1:0]   bit_idx;
    logic               last_flag;
    logic               in_frame;
    logic [PAT_MAX-1:0] history;
    logic [HC_W-1:0]    hist_cnt;
    logic [PAT_MAX-1:0] pat_r;
    logic [LEN_W-1:0]   len_r;
    logic               ovl_r;

    logic               hs_c;
    logic               cur_bit_c;
    logic [WORD_W-1:0]  shift_nxt_c;
    logic [PAT_MAX-1:0] hist_nxt_c;
    logic [HC_W-1:0]    hcnt_nxt_c;
    logic [PAT_MAX-1:0] mask_c;
    logic               match_c;
    logic               last_bit_c;
    logic [LEN_W-1:0]   len_clamp_c;
    logic [CNT_W-1:0]   cnt_inc_c;

    // Length 0 behaves as 1; lengths beyond the history depth are clamped.
    always_comb begin
        len_clamp_c = LEN_W'(cfg_len);
        if (cfg_len == 4'd0) begin
            len_clamp_c = LEN_W'(1);
        end else if (32'(cfg_len) > PAT_MAX) begin
            len_clamp_c = LEN_W'(PAT_MAX);
        end
    end

    // Serial datapath: next bit, post-shift history and the match decision on it.
    always_comb begin
`ifdef SEQ_CTRL_LSB_FIRST_EN
        cur_bit_c   = shift_reg[0];
        shift_nxt_c = shift_reg >> 1;
`else
        cur_bit_c   = shift_reg[WORD_W-1];
        shift_nxt_c = shift_reg << 1;
`endif
        hist_nxt_c = (history << 1) | PAT_MAX'(cur_bit_c);
        hcnt_nxt_c = (hist_cnt == HC_W'(PAT_MAX)) ? hist_cnt : hist_cnt + 1'b1;
        mask_c     = '0;
        for (int i = 0; i < int'(PAT_MAX); i++) begin
            mask_c[i] = (i < int'(len_r));
        end
        match_c    = (hcnt_nxt_c >= HC_W'(len_r)) &&
                     ((hist_nxt_c & mask_c) == (pat_r & mask_c));
        last_bit_c = (bit_idx == IDX_W'(WORD_W - 1));
        hs_c       = in_valid && in_ready;
        cnt_inc_c  = (&match_count) ? match_count : match_count + 1'b1;
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state       <= S_IDLE;
            in_ready    <= 1'b1;
            busy        <= 1'b0;
            seq_seen    <= 1'b0;
            done        <= 1'b0;
            match_count <= '0;
            shift_reg   <= '0;
            bit_idx     <= '0;
            last_flag   <= 1'b0;
            in_frame    <= 1'b0;
            history     <= '0;
            hist_cnt    <= '0;
            pat_r       <= DEF_PAT;
            len_r       <= DEF_LEN;
            ovl_r       <= 1'b1;
        end else begin
            seq_seen <= 1'b0;
            done     <= 1'b0;
            unique case (state)
                S_IDLE: begin
                    if (cfg_we) begin
                        pat_r <= cfg_pattern;
                        len_r <= len_clamp_c;
                        ovl_r <= cfg_overlap;
                    end
                    if (hs_c) begin
                        shift_reg <= in_data;
                        last_flag <= in_last;
                        bit_idx   <= '0;
                        in_frame  <= 1'b1;
                        state     <= S_SHIFT;
                        busy      <= 1'b1;
                        in_ready  <= (WORD_W == 1) && !in_last;
                        // A fresh frame never sees matches or bits from the previous one.
                        if (!in_frame) begin
                            match_count <= '0;
                            history     <= '0;
                            hist_cnt    <= '0;
                        end
                    end
                end
                S_SHIFT: begin
                    history  <= hist_nxt_c;
                    hist_cnt <= (match_c && !ovl_r) ? '0 : hcnt_nxt_c;
                    if (match_c) begin
                        seq_seen    <= 1'b1;
                        match_count <= cnt_inc_c;
                    end
                    if (!last_bit_c) begin
                        shift_reg <= shift_nxt_c;
                        bit_idx   <= bit_idx + 1'b1;
                        in_ready  <= (bit_idx == IDX_W'(WORD_W - 2)) && !last_flag;
                    end else if (last_flag) begin
                        state    <= S_DONE;
                        done     <= 1'b1;
                        in_ready <= 1'b0;
                    end else if (hs_c) begin
                        shift_reg <= in_data;
                        last_flag <= in_last;
                        bit_idx   <= '0;
                        in_ready  <= (WORD_W == 1) && !in_last;
                    end else begin
                        // Frame continues later; history stays so matches can span the gap.
                        state    <= S_IDLE;
                        in_ready <= 1'b1;
                        busy     <= 1'b0;
                    end
                end
                S_DONE: begin
                    history  <= '0;
                    hist_cnt <= '0;
                    in_frame <= 1'b0;
                    state    <= S_IDLE;
                    in_ready <= 1'b1;
                    busy     <= 1'b0;
                end
                default: begin
                    state    <= S_IDLE;
                    in_ready <= 1'b1;
                    busy     <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_seq_detect_ctrl.sv
// Scoreboard bench for seq_detect_ctrl: frame-level reference model predicts timed seq_seen/done events.
module tb_seq_detect_ctrl;

    localparam int unsigned WORD_W  = 8;
    localparam int unsigned PAT_MAX = 8;
    localparam int unsigned CNT_W   = 8;
    localparam int          KIND_SEEN = 1;
    localparam int          KIND_DONE = 2;
    localparam longint      CMAX = (longint'(1) << CNT_W) - 1;

    logic               clk = 1'b0;
    logic               reset;
    logic               cfg_we;
    logic [PAT_MAX-1:0] cfg_pattern;
    logic [3:0]         cfg_len;
    logic               cfg_overlap;
    logic               in_valid;
    logic               in_ready;
    logic [WORD_W-1:0]  in_data;
    logic               in_last;
    logic               seq_seen;
    logic [CNT_W-1:0]   match_count;
    logic               busy;
    logic               done;

    seq_detect_ctrl #(.WORD_W(WORD_W), .PAT_MAX(PAT_MAX), .CNT_W(CNT_W)) dut (
        .clk(clk), .reset(reset), .cfg_we(cfg_we), .cfg_pattern(cfg_pattern),
        .cfg_len(cfg_len), .cfg_overlap(cfg_overlap), .in_valid(in_valid),
        .in_ready(in_ready), .in_data(in_data), .in_last(in_last),
        .seq_seen(seq_seen), .match_count(match_count), .busy(busy), .done(done)
    );

    always #5 clk = ~clk;

    longint cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_cmp = 0;
    int n_err = 0;

    typedef struct {
        int     kind;
        longint cyc;
        longint cnt;
    } ev_t;
    ev_t exp_q[$];

    // Reference model state: bits of the open frame, bits since last non-overlap restart.
    bit                 m_hist[$];
    int                 m_run;
    longint             m_cnt;
    bit                 m_open;
    logic [PAT_MAX-1:0] m_pat;
    int                 m_len;
    bit                 m_ovl;

    task automatic check(input string name, input longint act, input longint exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    function automatic void model_defaults();
        m_pat  = 8'h0B;
        m_len  = 4;
        m_ovl  = 1'b1;
        m_open = 1'b0;
        m_cnt  = 0;
    endfunction

    function automatic void model_cfg(input logic [PAT_MAX-1:0] p, input logic [3:0] l, input bit o);
        m_pat = p;
        if (l == 0) m_len = 1;
        else if (int'(l) > int'(PAT_MAX)) m_len = PAT_MAX;
        else m_len = int'(l);
        m_ovl = o;
    endfunction

    function automatic void model_word(input logic [WORD_W-1:0] d, input bit last, input longint h);
        bit b;
        bit ok;
        if (!m_open) begin
            m_hist.delete();
            m_run  = 0;
            m_cnt  = 0;
            m_open = 1'b1;
        end
        for (int k = 0; k < int'(WORD_W); k++) begin
`ifdef SEQ_CTRL_LSB_FIRST_EN
            b = d[k];
`else
            b = d[WORD_W-1-k];
`endif
            m_hist.push_back(b);
            m_run++;
            if (m_run >= m_len) begin
                ok = 1'b1;
                for (int j = 0; j < m_len; j++)
                    if (m_hist[m_hist.size()-1-j] != m_pat[j]) ok = 1'b0;
                if (ok) begin
                    if (m_cnt < CMAX) m_cnt++;
                    exp_q.push_back('{KIND_SEEN, h + k + 1, m_cnt});
                    if (!m_ovl) m_run = 0;
                end
            end
        end
        if (last) begin
            exp_q.push_back('{KIND_DONE, h + WORD_W, m_cnt});
            m_open = 1'b0;
        end
    endfunction

    task automatic pop_check(input int kind, input string name);
        ev_t e;
        if (exp_q.size() == 0) begin
            n_cmp++;
            n_err++;
            $display("FAIL unexpected_%s: got pulse at cycle %0d, expected none", name, cyc);
        end else begin
            e = exp_q.pop_front();
            check({name, "_kind"}, kind, e.kind);
            check({name, "_cycle"}, cyc, e.cyc);
            check({name, "_count"}, longint'(match_count), e.cnt);
        end
    endtask

    // Monitor: consume expected events as the DUT pulses, flag any that were skipped.
    always @(negedge clk) begin
        if (reset === 1'b1) begin
            while (exp_q.size() > 0 && exp_q[0].cyc < cyc) begin
                n_cmp++;
                n_err++;
                $display("FAIL missed_event: got nothing at cycle %0d, expected kind %0d", exp_q[0].cyc, exp_q[0].kind);
                void'(exp_q.pop_front());
            end
            if (seq_seen) pop_check(KIND_SEEN, "seq_seen");
            if (done) pop_check(KIND_DONE, "done");
        end
    end

    task automatic send_word(input logic [WORD_W-1:0] d, input bit last, input bit do_cfg,
                             input logic [PAT_MAX-1:0] p, input logic [3:0] l, input bit o,
                             output longint h);
        bit got;
        in_data  = d;
        in_last  = last;
        in_valid = 1'b1;
        if (do_cfg) begin
            cfg_we      = 1'b1;
            cfg_pattern = p;
            cfg_len     = l;
            cfg_overlap = o;
        end
        got = 1'b0;
        for (int i = 0; i < 64 && !got; i++) begin
            @(negedge clk);
            if (in_ready) got = 1'b1;
        end
        if (!got) begin
            n_cmp++;
            n_err++;
            $display("FAIL handshake_timeout: got in_ready=0 for 64 cycles, expected 1");
            in_valid = 1'b0;
            cfg_we   = 1'b0;
            h        = -1;
        end else begin
            @(posedge clk);
            #1;
            h        = cyc;
            in_valid = 1'b0;
            cfg_we   = 1'b0;
            if (do_cfg) model_cfg(p, l, o);
            model_word(d, last, h);
        end
    endtask

    task automatic cfg_write(input logic [PAT_MAX-1:0] p, input logic [3:0] l, input bit o);
        cfg_we      = 1'b1;
        cfg_pattern = p;
        cfg_len     = l;
        cfg_overlap = o;
        @(posedge clk);
        #1;
        cfg_we = 1'b0;
    endtask

    task automatic drain(input string name, input longint exp_cnt);
        int i;
        i = 0;
        while ((exp_q.size() != 0 || busy) && i < 200) begin
            @(posedge clk);
            #1;
            i++;
        end
        check({name, "_pending"}, exp_q.size(), 0);
        check({name, "_busy"}, longint'(busy), 0);
        check({name, "_model_count"}, longint'(match_count), m_cnt);
        if (exp_cnt >= 0) check({name, "_count"}, longint'(match_count), exp_cnt);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got no finish by cycle %0d, expected finish", cyc);
        $fatal(1, "watchdog");
    end

    initial begin
        longint h, h1, h2;
        int nw, gap;
        logic [PAT_MAX-1:0] rp;
        logic [3:0] rl;
        bit ro;

        reset = 1'b0; cfg_we = 1'b0; cfg_pattern = '0; cfg_len = '0; cfg_overlap = 1'b0;
        in_valid = 1'b0; in_data = '0; in_last = 1'b0;
        model_defaults();
        repeat (3) @(posedge clk);
        #1;
        check("rst_in_ready", longint'(in_ready), 1);
        check("rst_busy", longint'(busy), 0);
        check("rst_seq_seen", longint'(seq_seen), 0);
        check("rst_done", longint'(done), 0);
        check("rst_count", longint'(match_count), 0);
        reset = 1'b1;
        @(posedge clk);
        #1;

        // Default config, overlapping 1011 in 1011_0110.
        send_word(8'hB6, 1'b1, 1'b0, '0, '0, 1'b0, h);
        drain("t1_overlap", 2);

        // Non-overlap written together with the handshake.
        send_word(8'hB6, 1'b1, 1'b1, 8'h0B, 4'd4, 1'b0, h);
        drain("t2_nonoverlap", 1);

        // Match spanning a back-to-back word boundary.
        send_word(8'h05, 1'b0, 1'b1, 8'h0B, 4'd4, 1'b1, h1);
        send_word(8'h80, 1'b1, 1'b0, '0, '0, 1'b0, h2);
        check("t3_no_gap", h2, h1 + WORD_W);
        drain("t3_cross", 1);

        send_word(8'hFF, 1'b1, 1'b1, 8'h07, 4'd3, 1'b1, h);
        drain("t4_111_ovl", 6);
        send_word(8'hFF, 1'b1, 1'b1, 8'h07, 4'd3, 1'b0, h);
        drain("t4_111_novl", 2);
        send_word(8'hFF, 1'b1, 1'b0, '0, '0, 1'b0, h);
        cfg_write(8'h01, 4'd1, 1'b1);
        drain("t4_cfg_in_shift", 2);

        // Reset while bit 3 of a word is due.
        send_word(8'h6F, 1'b1, 1'b0, '0, '0, 1'b0, h);
        repeat (3) @(posedge clk);
        #1;
        reset = 1'b0;
        @(posedge clk);
        #1;
        exp_q.delete();
        model_defaults();
        check("t5_in_ready", longint'(in_ready), 1);
        check("t5_busy", longint'(busy), 0);
        check("t5_count", longint'(match_count), 0);
        check("t5_done", longint'(done), 0);
        reset = 1'b1;
        repeat (12) @(posedge clk);
        #1;
        send_word(8'hB6, 1'b1, 1'b0, '0, '0, 1'b0, h);
        drain("t5_defaults", 2);

        // Saturating counter; cfg_len=0 acts as length 1.
        send_word(8'hFF, 1'b0, 1'b1, 8'h01, 4'd0, 1'b1, h);
        for (int w = 1; w < 33; w++) send_word(8'hFF, w == 32, 1'b0, '0, '0, 1'b0, h);
        drain("t6_saturate", CMAX);

        // Randomized frames: config, gaps, ignored mid-shift writes.
        for (int f = 0; f < 30; f++) begin
            nw = $urandom_range(1, 4);
            rp = PAT_MAX'($urandom);
            rl = 4'($urandom_range(0, 15));
            ro = 1'($urandom);
            for (int w = 0; w < nw; w++) begin
                send_word(WORD_W'($urandom), w == nw - 1, w == 0, rp, rl, ro, h);
                if ($urandom_range(0, 3) == 0)
                    cfg_write(PAT_MAX'($urandom), 4'($urandom_range(0, 15)), 1'($urandom));
                gap = (w == nw - 1) ? 0 : $urandom_range(0, 2);
                if (gap > 0) begin
                    repeat (gap) @(posedge clk);
                    #1;
                end
            end
            drain($sformatf("rand%0d", f), -1);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
